// File: rtl/interrupt_sequencer.sv
// Interrupt entry/exit sequencer: saves context, masks, vectors, then restores on reti.
// Latency: first entry strobe one cycle after the taking edge, pc_load four cycles after that.
// Backpressure: holds the core with stall during every sequencing state; requests are ignored outside IDLE.
module interrupt_sequencer #(
  parameter int          NUM_IRQ       = 9,
  parameter logic [15:0] VECTOR_BASE   = 16'h0100,
  parameter logic [15:0] VECTOR_STRIDE = 16'h0004
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               instr_boundary,
  input  logic               reti,
  input  logic [15:0]        pc_in,
  input  logic [15:0]        sp_in,
  input  logic [15:0]        ra_in,
  output logic               stall,
  output logic               r_backup,
  output logic               r_restore,
  output logic               return_address_write,
  output logic [15:0]        return_address_input,
  output logic               stack_pointer_write,
  output logic [15:0]        stack_pointer_input,
  output logic               interrupt_write,
  output logic [NUM_IRQ-1:0] interrupt_input,
  output logic               pc_load,
  output logic [15:0]        pc_value,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               in_service
);

  localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [3:0] {
    IDLE, SAVE_R, SAVE_RA, PUSH_SP, MASK, VECTOR, SERVICE,
    REST_R, POP_SP, REST_MASK, RETURN
  } state_t;

  state_t              state_q;
  logic [IDXW-1:0]     idx_q;
  logic [NUM_IRQ-1:0]  saved_mask_q;

  logic [NUM_IRQ-1:0]  pend;
  logic                pend_any;
  logic [IDXW-1:0]     pend_idx;
  logic [15:0]         idx_ext;
  logic [15:0]         vec_addr;

  // Lowest-index enabled request wins; the downward loop leaves the smallest index last.
  always_comb begin
    pend     = irq_req & irq_mask;
    pend_any = |pend;
    pend_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (pend[i]) pend_idx = IDXW'(i);
    end
  end

  // Vector address from the latched index, wrapping at 16 bits.
  always_comb begin
    idx_ext  = 16'(idx_q);
    vec_addr = VECTOR_BASE + idx_ext * VECTOR_STRIDE;
  end

  // State machine with registered outputs: each output reflects the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q              <= IDLE;
      idx_q                <= '0;
      saved_mask_q         <= '0;
      stall                <= 1'b0;
      r_backup             <= 1'b0;
      r_restore            <= 1'b0;
      return_address_write <= 1'b0;
      return_address_input <= '0;
      stack_pointer_write  <= 1'b0;
      stack_pointer_input  <= '0;
      interrupt_write      <= 1'b0;
      interrupt_input      <= '0;
      pc_load              <= 1'b0;
      pc_value             <= '0;
      irq_ack              <= '0;
      in_service           <= 1'b0;
    end else begin
      // Strobes and data default low so every pulse lasts exactly one cycle.
      stall                <= 1'b1;
      r_backup             <= 1'b0;
      r_restore            <= 1'b0;
      return_address_write <= 1'b0;
      return_address_input <= '0;
      stack_pointer_write  <= 1'b0;
      stack_pointer_input  <= '0;
      interrupt_write      <= 1'b0;
      interrupt_input      <= '0;
      pc_load              <= 1'b0;
      pc_value             <= '0;
      irq_ack              <= '0;
      in_service           <= 1'b0;

      case (state_q)
        IDLE: begin
          if (instr_boundary && pend_any) begin
            state_q      <= SAVE_R;
            idx_q        <= pend_idx;
            saved_mask_q <= irq_mask;
            r_backup     <= 1'b1;
          end else begin
            stall <= 1'b0;
          end
        end
        SAVE_R: begin
          state_q              <= SAVE_RA;
          return_address_write <= 1'b1;
          return_address_input <= pc_in;
        end
        SAVE_RA: begin
          state_q             <= PUSH_SP;
          stack_pointer_write <= 1'b1;
          stack_pointer_input <= sp_in - 16'd1;
        end
        PUSH_SP: begin
          state_q         <= MASK;
          interrupt_write <= 1'b1;
          interrupt_input <= '0;
        end
        MASK: begin
          state_q  <= VECTOR;
          pc_load  <= 1'b1;
          pc_value <= vec_addr;
          irq_ack  <= NUM_IRQ'(1) << idx_q;
        end
        VECTOR: begin
          state_q    <= SERVICE;
          stall      <= 1'b0;
          in_service <= 1'b1;
        end
        SERVICE: begin
          if (reti) begin
            state_q   <= REST_R;
            r_restore <= 1'b1;
          end else begin
            stall      <= 1'b0;
            in_service <= 1'b1;
          end
        end
        REST_R: begin
          state_q             <= POP_SP;
          stack_pointer_write <= 1'b1;
          stack_pointer_input <= sp_in + 16'd1;
        end
        POP_SP: begin
          state_q         <= REST_MASK;
          interrupt_write <= 1'b1;
          interrupt_input <= saved_mask_q;
        end
        REST_MASK: begin
          state_q  <= RETURN;
          pc_load  <= 1'b1;
          pc_value <= ra_in;
        end
        RETURN: begin
          state_q <= IDLE;
          stall   <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          stall   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL provide parameter NUM_IRQ, default 9, number of request lines; equals the register-file interrupt field width.
REQ-002 SHALL provide parameter VECTOR_BASE, default 16'h0100, address of vector 0.
REQ-003 SHALL provide parameter VECTOR_STRIDE, default 16'h0004, address step between vectors.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port irq_req  input  NUM_IRQ  level-sensitive interrupt requests.
REQ-007 SHALL have port irq_mask  input  NUM_IRQ  current enable mask (register-file interrupt field); 1 = enabled.
REQ-008 SHALL have port instr_boundary  input  1  core is between instructions; interrupts may be taken.
REQ-009 SHALL have port reti  input  1  single-cycle return-from-interrupt request.
REQ-010 SHALL have ports pc_in, sp_in, ra_in  input  16 each  current PC, stack pointer and return address.
REQ-011 SHALL have port stall  output  1  holds the core while sequencing.
REQ-012 SHALL have ports r_backup, r_restore  output  1 each  register-file r save/restore strobes.
REQ-013 SHALL have ports return_address_write (1) and return_address_input (16)  output  return-address update.
REQ-014 SHALL have ports stack_pointer_write (1) and stack_pointer_input (16)  output  stack-pointer update.
REQ-015 SHALL have ports interrupt_write (1) and interrupt_input (NUM_IRQ)  output  mask update.
REQ-016 SHALL have ports pc_load (1) and pc_value (16)  output  PC redirect.
REQ-017 SHALL have port irq_ack  output  NUM_IRQ  one-hot acknowledge of the taken line.
REQ-018 SHALL have port in_service  output  1  handler executing.

Function
REQ-019 SHALL implement states IDLE, SAVE_R, SAVE_RA, PUSH_SP, MASK, VECTOR, SERVICE, REST_R, POP_SP, REST_MASK, RETURN; every output registered.
REQ-020 SHALL take an interrupt from IDLE when instr_boundary=1 and (irq_req & irq_mask) != 0 at a clock edge; the lowest-index pending line wins and its index is latched.
REQ-021 SHALL latch irq_mask into an internal saved_mask on the taking edge.
REQ-022 SHALL sequence entry one state per cycle: SAVE_R (r_backup=1), SAVE_RA (return_address_write=1, return_address_input=pc_in), PUSH_SP (stack_pointer_write=1, input=sp_in-1), MASK (interrupt_write=1, input=0), VECTOR (pc_load=1, pc_value=VECTOR_BASE+index*VECTOR_STRIDE, irq_ack one-hot of index), then SERVICE.
REQ-023 SHALL assert the first entry strobe (r_backup) in the cycle after the taking edge; pc_load follows exactly 4 cycles later.
REQ-024 SHALL exit SERVICE on reti=1 at a clock edge, sequencing REST_R (r_restore=1), POP_SP (stack_pointer_write=1, input=sp_in+1), REST_MASK (interrupt_write=1, input=saved_mask), RETURN (pc_load=1, pc_value=ra_in), then IDLE.
REQ-025 SHALL pulse each strobe (r_backup, r_restore, *_write, pc_load, irq_ack) for exactly one cycle; all are 0 in every other state.
REQ-026 SHALL compute stack-pointer arithmetic modulo 2^16 (16'h0000-1 = 16'hFFFF; 16'hFFFF+1 = 16'h0000).
REQ-027 SHALL compute vector address modulo 2^16.
REQ-028 SHALL drive stall=1 in all states except IDLE and SERVICE; in_service=1 only in SERVICE.
REQ-029 SHALL ignore irq_req in every state except IDLE (no nesting; backup is single-level).
REQ-030 SHALL ignore reti outside SERVICE; in IDLE, a simultaneous interrupt is still taken.
REQ-031 SHALL ignore requests deasserting after the taking edge; the latched index is used for the whole entry.
REQ-032 SHALL hold data outputs (return_address_input, stack_pointer_input, interrupt_input, pc_value) at 0 when their strobe is 0.

Reset
REQ-033 SHALL, on rst_n=0, immediately (asynchronously) force state IDLE, saved_mask=0, latched index=0, and all outputs 0.
REQ-034 SHALL, when reset asserts mid-sequence, abandon the sequence with no further strobes; after release operation starts from IDLE.
REQ-035 SHALL evaluate a request no earlier than the first posedge clk after rst_n rises.

Verification
REQ-036 SHALL cover: irq_req=9'h004, irq_mask=9'h1FF, instr_boundary=1, pc_in=16'h0040, sp_in=16'h0200 -> r_backup, RA write 16'h0040, SP write 16'h01FF, mask write 0, pc_load 16'h0108, irq_ack=9'h004 on consecutive cycles.
REQ-037 SHALL cover: irq_req=9'h014, mask=9'h1FF -> index 2 taken; irq_req=9'h014, mask=9'h1FB -> index 4, pc_value 16'h0110.
REQ-038 SHALL cover: in SERVICE, reti=1, sp_in=16'hFFFF, ra_in=16'h0041, saved_mask=9'h1FF -> r_restore, SP write 16'h0000, mask write 9'h1FF, pc_load 16'h0041, then IDLE.
REQ-039 SHALL cover: irq_req=9'h001 with instr_boundary=0 -> no strobes; request during SERVICE -> ignored until IDLE.
REQ-040 SHALL cover: rst_n=0 during PUSH_SP -> all outputs 0 before next clock edge, no further strobes, and IDLE after release.
REQ-041 SHALL cover: sp_in=16'h0000 on entry -> stack_pointer_input=16'hFFFF.
